// File: rtl/uart_rx_fifo_axils_if.sv
// AXI-Lite slave bus bundle for uart_rx_fifo_axils.
//   slave  modport: used by the peripheral (accepts AW/W/AR, returns B/R).
//   master modport: used by whoever drives the bus (CPU model, testbench).
interface uart_rx_fifo_axils_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/uart_rx_fifo_axils.sv
// UART receiver with RX FIFO behind an AXI-Lite register slave.
//   S_AXI_ACLK   : sole clock
//   S_AXI_ARESET : asynchronous active-high reset
//   s_axi        : AXI-Lite slave (BAUD_DIV 0x0, CTRL 0x4, STATUS 0x8, RXDATA 0xC)
//   UART_RX      : asynchronous serial input, idle high
//   IRQ          : registered level interrupt
module uart_rx_fifo_axils #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH         = 8,
  parameter int unsigned FIFO_DEPTH         = 16,
  parameter int unsigned DEFAULT_DIV        = 10417
) (
  input  logic                S_AXI_ACLK,
  input  logic                S_AXI_ARESET,
  uart_rx_fifo_axils_if.slave s_axi,
  input  logic                UART_RX,
  output logic                IRQ
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  logic [15:0]                   baud_div_q;
  logic                          rx_en_q, parity_en_q, parity_odd_q, intr_en_q;
  logic                          overrun_q, parity_err_q, frame_err_q, irq_q;
  logic                          awready_q, bvalid_q, rvalid_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  logic                          rx_meta_q, rx_sync_q, rx_prev_q;
  state_e                        state_q, state_d;
  logic [15:0]                   cnt_q, cnt_d, half_m1, full_m1;
  logic [2:0]                    bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]         shift_q, shift_d;
  logic [DATA_WIDTH-1:0]         mem_q [FIFO_DEPTH];
  logic [AW:0]                   wr_ptr_q, rd_ptr_q, level;
  logic                          empty, full;
  logic                          wr_hs, ar_hs, pop, flush, push_req, push_ok, ovr_set;
  logic                          par_set, frm_set;
  logic [1:0]                    wr_sel, rd_sel;
  logic [15:0]                   baud_wr;
  logic [2:0]                    w1c;
  logic [31:0]                   rd_val;
  logic                          unused_bits;

  assign level = wr_ptr_q - rd_ptr_q;
  assign empty = (level == '0);
  assign full  = (level == (AW+1)'(FIFO_DEPTH));

  // Bus decode: word offset is the top two address bits.
  assign wr_hs  = awready_q & s_axi.awvalid & s_axi.wvalid;
  assign ar_hs  = s_axi.arvalid & ~rvalid_q;
  assign wr_sel = s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1 -: 2];
  assign rd_sel = s_axi.araddr[C_S_AXI_ADDR_WIDTH-1 -: 2];
  assign pop    = ar_hs & (rd_sel == 2'd3) & ~empty;
  assign flush  = wr_hs & (wr_sel == 2'd1) & s_axi.wstrb[1] & s_axi.wdata[9];
  assign w1c    = (wr_hs && wr_sel == 2'd2 && s_axi.wstrb[0]) ? s_axi.wdata[4:2] : 3'b000;
  assign baud_wr = {s_axi.wstrb[1] ? s_axi.wdata[15:8] : baud_div_q[15:8],
                    s_axi.wstrb[0] ? s_axi.wdata[7:0]  : baud_div_q[7:0]};

  // A full FIFO still accepts a push if the head leaves on the same edge.
  assign push_ok = push_req & ~flush & (~full | pop);
  assign ovr_set = push_req & ~flush & full & ~pop;

  assign unused_bits = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0], s_axi.wdata[31:16],
                         s_axi.wstrb[3:2]};

  always_comb begin
    rd_val = '0;
    case (rd_sel)
      2'd0: rd_val[15:0] = baud_div_q;
      2'd1: begin
        rd_val[0] = rx_en_q;
        rd_val[1] = parity_en_q;
        rd_val[2] = parity_odd_q;
        rd_val[8] = intr_en_q;
      end
      2'd2: begin
        rd_val[0]    = ~empty;
        rd_val[1]    = full;
        rd_val[2]    = overrun_q;
        rd_val[3]    = parity_err_q;
        rd_val[4]    = frame_err_q;
        rd_val[15:8] = 8'(level);
      end
      default: if (!empty) rd_val[DATA_WIDTH-1:0] = mem_q[rd_ptr_q[AW-1:0]];
    endcase
  end

  // Receiver FSM
  assign half_m1 = {1'b0, baud_div_q[15:1]} - 16'd1;
  assign full_m1 = baud_div_q - 16'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 16'd1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_set   = 1'b0;
    frm_set   = 1'b0;
    push_req  = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d     = '0;
        bit_cnt_d = '0;
        if (rx_en_q && rx_prev_q && !rx_sync_q) state_d = StStart;
      end
      StStart: if (cnt_q == half_m1) begin
        cnt_d   = '0;
        state_d = rx_sync_q ? StIdle : StData;
      end
      StData: if (cnt_q == full_m1) begin
        cnt_d     = '0;
        shift_d   = {rx_sync_q, shift_q[DATA_WIDTH-1:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'(DATA_WIDTH - 1)) state_d = parity_en_q ? StParity : StStop;
      end
      StParity: if (cnt_q == full_m1) begin
        cnt_d   = '0;
        par_set = rx_sync_q != ((^shift_q) ^ parity_odd_q);
        state_d = StStop;
      end
      StStop: if (cnt_q == full_m1) begin
        state_d  = StIdle;
        push_req = rx_sync_q;
        frm_set  = ~rx_sync_q;
      end
      default: state_d = StIdle;
    endcase
    // Disabling the receiver abandons any frame silently.
    if (!rx_en_q) begin
      state_d  = StIdle;
      par_set  = 1'b0;
      frm_set  = 1'b0;
      push_req = 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      rx_meta_q <= UART_RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      baud_div_q   <= 16'(DEFAULT_DIV);
      rx_en_q      <= 1'b1;
      parity_en_q  <= 1'b0;
      parity_odd_q <= 1'b0;
      intr_en_q    <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      irq_q        <= 1'b0;
      awready_q    <= 1'b0;
      bvalid_q     <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
    end else begin
      if (wr_hs && wr_sel == 2'd0) baud_div_q <= (baud_wr < 16'd4) ? 16'd4 : baud_wr;
      if (wr_hs && wr_sel == 2'd1) begin
        if (s_axi.wstrb[0]) begin
          rx_en_q      <= s_axi.wdata[0];
          parity_en_q  <= s_axi.wdata[1];
          parity_odd_q <= s_axi.wdata[2];
        end
        if (s_axi.wstrb[1]) intr_en_q <= s_axi.wdata[8];
      end
      // Hardware set beats a simultaneous W1C.
      overrun_q    <= (overrun_q & ~w1c[0]) | ovr_set;
      parity_err_q <= (parity_err_q & ~w1c[1]) | par_set;
      frame_err_q  <= (frame_err_q & ~w1c[2]) | frm_set;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      irq_q     <= intr_en_q & (~empty | overrun_q | parity_err_q | frame_err_q);
      awready_q <= s_axi.awvalid & s_axi.wvalid & ~bvalid_q & ~awready_q;
      if (wr_hs)             bvalid_q <= 1'b1;
      else if (s_axi.bready) bvalid_q <= 1'b0;
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_val;
      end else if (s_axi.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = awready_q;
  assign s_axi.bresp   = 2'b00;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.arready = ~rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = 2'b00;
  assign s_axi.rvalid  = rvalid_q;
  assign IRQ           = irq_q;
endmodule

// File: tb/tb_uart_rx_fifo_axils.sv
// Self-checking bench for uart_rx_fifo_axils: AXI-Lite master tasks, a UART line
// driver, and a queue-based model of FIFO contents and sticky flags.
module tb_uart_rx_fifo_axils;
  localparam int unsigned DIV   = 16;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_rx = 1'b1;
  logic irq;

  always #5 clk = ~clk;

  uart_rx_fifo_axils_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) axi ();

  uart_rx_fifo_axils #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .DATA_WIDTH        (8),
    .FIFO_DEPTH        (DEPTH),
    .DEFAULT_DIV       (10417)
  ) dut (
    .S_AXI_ACLK  (clk),
    .S_AXI_ARESET(rst),
    .s_axi       (axi),
    .UART_RX     (uart_rx),
    .IRQ         (irq)
  );

  // Reference model
  logic [7:0] model_q[$];
  bit m_ovr, m_perr, m_ferr, m_en;
  int tests, fails;

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[15:8] = 8'(model_q.size());
    s[4] = m_ferr;
    s[3] = m_perr;
    s[2] = m_ovr;
    s[1] = (model_q.size() == DEPTH);
    s[0] = (model_q.size() != 0);
    return s;
  endfunction

  task automatic model_reset();
    model_q.delete();
    m_ovr = 0; m_perr = 0; m_ferr = 0; m_en = 1;
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
    bit done;
    @(posedge clk); #1;
    axi.awaddr = addr; axi.awvalid = 1'b1;
    axi.wdata = data; axi.wstrb = strb; axi.wvalid = 1'b1;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = axi.awready && axi.wready;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL aw_handshake addr=%h: awready=%b required 1", addr, axi.awready);
    end
    @(posedge clk); #1;
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (axi.bvalid) done = 1;
      else @(negedge clk);
    end
    tests++;
    if (!done || axi.bresp !== 2'b00) begin
      fails++;
      $display("FAIL b_response addr=%h: bvalid=%b bresp=%b required 1/00", addr,
               axi.bvalid, axi.bresp);
    end
    if (axi.bready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    bit done;
    @(posedge clk); #1;
    axi.araddr = addr; axi.arvalid = 1'b1;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = axi.arready;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL ar_handshake addr=%h: arready=%b required 1", addr, axi.arready);
    end
    @(posedge clk); #1;
    axi.arvalid = 1'b0;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (axi.rvalid) done = 1;
      else @(negedge clk);
    end
    if (!done || axi.rresp !== 2'b00) begin
      tests++; fails++;
      $display("FAIL r_response addr=%h: rvalid=%b rresp=%b required 1/00", addr,
               axi.rvalid, axi.rresp);
    end
    data = axi.rdata;
    @(posedge clk); #1;
  endtask

  task automatic drive_bit(input logic b);
    uart_rx = b;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  // Sends one frame and applies its effect to the model.
  task automatic send_char(input logic [7:0] d, input bit par_en, input bit par_odd,
                           input bit bad_par, input bit stop_bit);
    int ones;
    logic pbit;
    ones = $countones(d);
    pbit = logic'((ones % 2) == 1) ^ par_odd ^ bad_par;
    @(posedge clk); #1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (par_en) drive_bit(pbit);
    drive_bit(stop_bit);
    uart_rx = 1'b1;
    repeat (4) @(posedge clk);
    if (m_en) begin
      if (par_en && ((((ones + int'(pbit)) % 2) == 1) != par_odd)) m_perr = 1;
      if (!stop_bit) m_ferr = 1;
      else if (model_q.size() == DEPTH) m_ovr = 1;
      else model_q.push_back(d);
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    model_reset();
    rst = 1'b1;
    #12;
    tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b required 0", irq); end
    tests++;
    if ({axi.awready, axi.wready, axi.bvalid, axi.rvalid} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_handshake: aw/w/b/r=%b required 0000",
               {axi.awready, axi.wready, axi.bvalid, axi.rvalid});
    end
    tests++;
    if (axi.rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h required 0", axi.rdata); end
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (axi.arready !== 1'b1) begin fails++; $display("FAIL reset_arready: got %b required 1", axi.arready); end
    axi_read(4'h0, rd);
    tests++;
    if (rd !== 32'd10417) begin fails++; $display("FAIL reset_baud: got %h required %h", rd, 32'd10417); end
    axi_read(4'h4, rd);
    tests++;
    if (rd !== 32'h1) begin fails++; $display("FAIL reset_ctrl: got %h required 1", rd); end
    axi_read(4'h8, rd);
    tests++;
    if (rd !== exp_status()) begin fails++; $display("FAIL reset_status: got %h required %h", rd, exp_status()); end
  endtask

  task automatic test_basic();
    logic [31:0] rd;
    axi_write(4'h0, DIV, 4'hF);
    send_char(8'hA5, 0, 0, 0, 1);
    axi_read(4'h8, rd);
    tests++;
    if (rd !== 32'h0101) begin fails++; $display("FAIL basic_status: got %h required 00000101", rd); end
    axi_read(4'hC, rd);
    void'(model_q.pop_front());
    tests++;
    if (rd !== 32'h0000_00A5) begin fails++; $display("FAIL basic_rxdata: got %h required 000000a5", rd); end
    axi_read(4'h8, rd);
    tests++;
    if (rd !== 32'h0) begin fails++; $display("FAIL basic_status_after: got %h required 0", rd); end
  endtask

  task automatic test_baud();
    logic [31:0] rd;
    axi_write(4'h0, 32'h2, 4'hF);
    axi_read(4'h0, rd);
    tests++;
    if (rd !== 32'h4) begin fails++; $display("FAIL baud_min: got %h required 4", rd); end
    axi_write(4'h0, 32'hABCD_12FF, 4'b0001);
    axi_read(4'h0, rd);
    tests++;
    if (rd !== 32'h00FF) begin fails++; $display("FAIL baud_wstrb: got %h required 000000ff", rd); end
    axi_write(4'h0, DIV, 4'hF);
  endtask

  task automatic test_overrun();
    logic [31:0] rd, exp;
    for (int i = 0; i <= DEPTH; i++) send_char(8'(i), 0, 0, 0, 1);
    axi_read(4'h8, rd);
    tests++;
    if (rd !== exp_status() || rd[2:1] !== 2'b11) begin
      fails++; $display("FAIL overrun_status: got %h required %h", rd, exp_status());
    end
    for (int i = 0; i <= DEPTH; i++) begin
      exp = (model_q.size() != 0) ? {24'h0, model_q.pop_front()} : 32'h0;
      axi_read(4'hC, rd);
      tests++;
      if (rd !== exp) begin fails++; $display("FAIL overrun_read%0d: got %h required %h", i, rd, exp); end
    end
    axi_write(4'h8, 32'h4, 4'hF);
    m_ovr = 0;
    axi_read(4'h8, rd);
    tests++;
    if (rd !== exp_status()) begin fails++; $display("FAIL overrun_clear: got %h required %h", rd, exp_status()); end
  endtask

  task automatic test_parity();
    logic [31:0] rd;
    axi_write(4'h4, 32'h103, 4'hF);
    send_char(8'h01, 1, 0, 1, 1);
    axi_read(4'h8, rd);
    tests++;
    if (rd !== exp_status() || rd[3] !== 1'b1) begin
      fails++; $display("FAIL parity_status: got %h required %h", rd, exp_status());
    end
    tests++;
    if (irq !== 1'b1) begin fails++; $display("FAIL parity_irq_set: got %b required 1", irq); end
    axi_write(4'h8, 32'h8, 4'hF);
    m_perr = 0;
    @(negedge clk);
    tests++;
    if (irq !== 1'b1) begin fails++; $display("FAIL parity_irq_hold: got %b required 1", irq); end
    axi_read(4'hC, rd);
    tests++;
    if (rd !== {24'h0, model_q.pop_front()}) begin fails++; $display("FAIL parity_data: got %h required 1", rd); end
    repeat (2) @(negedge clk);
    tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL parity_irq_clear: got %b required 0", irq); end
    axi_write(4'h4, 32'h1, 4'hF);
  endtask

  task automatic test_frame();
    logic [31:0] rd;
    send_char(8'h3C, 0, 0, 0, 0);
    axi_read(4'h8, rd);
    tests++;
    if (rd !== exp_status() || rd !== 32'h10) begin
      fails++; $display("FAIL frame_status: got %h required %h", rd, exp_status());
    end
    axi_write(4'h8, 32'h10, 4'hF);
    m_ferr = 0;
    @(posedge clk); #1;
    uart_rx = 1'b0;
    repeat (DIV / 4) @(posedge clk);
    #1;
    uart_rx = 1'b1;
    repeat (3 * DIV) @(posedge clk);
    axi_read(4'h8, rd);
    tests++;
    if (rd !== exp_status()) begin fails++; $display("FAIL glitch_status: got %h required %h", rd, exp_status()); end
  endtask

  task automatic test_flush();
    logic [31:0] rd;
    for (int i = 0; i < 3; i++) send_char(8'($urandom), 0, 0, 0, 1);
    axi_read(4'h8, rd);
    tests++;
    if (rd !== exp_status()) begin fails++; $display("FAIL flush_pre: got %h required %h", rd, exp_status()); end
    axi_write(4'h4, 32'h201, 4'b0011);
    model_q.delete();
    axi_read(4'h4, rd);
    tests++;
    if (rd !== 32'h1) begin fails++; $display("FAIL flush_ctrl: got %h required 1", rd); end
    axi_read(4'h8, rd);
    tests++;
    if (rd !== exp_status()) begin fails++; $display("FAIL flush_status: got %h required %h", rd, exp_status()); end
    axi_read(4'hC, rd);
    tests++;
    if (rd !== 32'h0) begin fails++; $display("FAIL empty_read: got %h required 0", rd); end
    axi_read(4'h8, rd);
    tests++;
    if (rd !== exp_status()) begin fails++; $display("FAIL empty_level: got %h required %h", rd, exp_status()); end
  endtask

  task automatic test_rx_disable();
    logic [31:0] rd;
    @(posedge clk); #1;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    axi_write(4'h4, 32'h0, 4'hF);
    m_en = 0;
    uart_rx = 1'b1;
    repeat (8 * DIV) @(posedge clk);
    send_char(8'h33, 0, 0, 0, 1);
    axi_write(4'h4, 32'h1, 4'hF);
    m_en = 1;
    axi_read(4'h8, rd);
    tests++;
    if (rd !== exp_status()) begin fails++; $display("FAIL rxdis_status: got %h required %h", rd, exp_status()); end
    send_char(8'h42, 0, 0, 0, 1);
    axi_read(4'hC, rd);
    tests++;
    if (rd !== {24'h0, model_q.pop_front()}) begin fails++; $display("FAIL rxdis_next: got %h required 42", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, exp;
    bit pe, po;
    for (int n = 0; n < 20; n++) begin
      pe = 1'($urandom);
      po = 1'($urandom);
      axi_write(4'h4, {29'h0, po, pe, 1'b1}, 4'hF);
      send_char(8'($urandom), pe, po, ($urandom_range(3) == 0), ($urandom_range(7) != 0));
      if ($urandom_range(2) == 0) begin
        exp = (model_q.size() != 0) ? {24'h0, model_q.pop_front()} : 32'h0;
        axi_read(4'hC, rd);
        tests++;
        if (rd !== exp) begin fails++; $display("FAIL rand_read%0d: got %h required %h", n, rd, exp); end
      end
    end
    axi_read(4'h8, rd);
    tests++;
    if (rd !== exp_status()) begin fails++; $display("FAIL rand_status: got %h required %h", rd, exp_status()); end
    while (model_q.size() != 0) begin
      exp = {24'h0, model_q.pop_front()};
      axi_read(4'hC, rd);
      tests++;
      if (rd !== exp) begin fails++; $display("FAIL rand_drain: got %h required %h", rd, exp); end
    end
    axi_write(4'h8, 32'h1C, 4'hF);
    m_ovr = 0; m_perr = 0; m_ferr = 0;
    axi_write(4'h4, 32'h1, 4'hF);
    axi_read(4'h8, rd);
    tests++;
    if (rd !== exp_status()) begin fails++; $display("FAIL rand_clear: got %h required %h", rd, exp_status()); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] rd;
    axi_write(4'h4, 32'h101, 4'hF);
    send_char(8'h11, 0, 0, 0, 1);
    @(negedge clk);
    tests++;
    if (irq !== 1'b1) begin fails++; $display("FAIL pre_reset_irq: got %b required 1", irq); end
    axi.bready = 1'b0;
    axi_write(4'h0, DIV, 4'hF);
    tests++;
    if (axi.bvalid !== 1'b1) begin fails++; $display("FAIL pending_bvalid: got %b required 1", axi.bvalid); end
    @(posedge clk); #1;
    uart_rx = 1'b0;
    repeat (3 * DIV) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    tests++;
    if ({irq, axi.awready, axi.wready, axi.bvalid, axi.rvalid} !== 5'b0 || axi.rdata !== 32'h0) begin
      fails++;
      $display("FAIL midreset_outputs: irq/aw/w/b/r=%b rdata=%h required 00000/0",
               {irq, axi.awready, axi.wready, axi.bvalid, axi.rvalid}, axi.rdata);
    end
    #10;
    uart_rx = 1'b1;
    axi.bready = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    model_reset();
    axi_read(4'h0, rd);
    tests++;
    if (rd !== 32'd10417) begin fails++; $display("FAIL midreset_baud: got %h required %h", rd, 32'd10417); end
    axi_read(4'h8, rd);
    tests++;
    if (rd !== exp_status()) begin fails++; $display("FAIL midreset_status: got %h required %h", rd, exp_status()); end
    axi_write(4'h0, DIV, 4'hF);
    send_char(8'h5A, 0, 0, 0, 1);
    axi_read(4'h8, rd);
    tests++;
    if (rd !== 32'h0101) begin fails++; $display("FAIL post_reset_status: got %h required 00000101", rd); end
    axi_read(4'hC, rd);
    tests++;
    if (rd !== 32'h5A) begin fails++; $display("FAIL post_reset_data: got %h required 0000005a", rd); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    axi.awaddr = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
    axi.bready = 1'b1;
    axi.araddr = '0; axi.arvalid = 1'b0;
    axi.rready = 1'b1;
    test_reset();
    test_basic();
    test_baud();
    test_overrun();
    test_parity();
    test_frame();
    test_flush();
    test_rx_disable();
    test_random();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
